// File: rtl/servo_pkg.sv
// Shared widths, default timing and FSM encoding for the four-channel servo PWM driver.
package servo_pkg;

  localparam int POS_W  = 8;
  localparam int CNT_W  = 32;
  localparam int NUM_CH = 4;

  localparam int DEF_PERIOD_CYCLES    = 2_000_000;
  localparam int DEF_MIN_PULSE_CYCLES = 100_000;
  localparam int DEF_CYCLES_PER_DEG   = 555;
  localparam int DEF_MAX_ANGLE        = 180;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/servo_width_calc.sv
// Angle-to-pulse-width conversion for one channel: clamp to the legal range, then scale and offset.
module servo_width_calc
  import servo_pkg::*;
#(
  parameter int MIN_PULSE_CYCLES = DEF_MIN_PULSE_CYCLES,
  parameter int CYCLES_PER_DEG   = DEF_CYCLES_PER_DEG,
  parameter int MAX_ANGLE        = DEF_MAX_ANGLE
) (
  input  logic [POS_W-1:0] pos,
  output logic [CNT_W-1:0] width,
  output logic             clamp
);

  localparam logic [POS_W-1:0] MAX_POS = POS_W'(MAX_ANGLE);
  localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] STEP_W  = CNT_W'(CYCLES_PER_DEG);

  logic [POS_W-1:0] angle_s;

  // Clamp the commanded angle and compute the pulse width in cycles
  always_comb begin
    clamp   = 1'b0;
    angle_s = pos;
    if (pos > MAX_POS) begin
      clamp   = 1'b1;
      angle_s = MAX_POS;
    end else begin
      clamp   = 1'b0;
      angle_s = pos;
    end
    width = MIN_W + (CNT_W'(angle_s) * STEP_W);
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// Four-channel hobby-servo PWM driver: one pulse per frame per pin, widths latched once per frame
// so sequencer updates never distort a pulse in flight.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int PERIOD_CYCLES    = DEF_PERIOD_CYCLES,
  parameter int MIN_PULSE_CYCLES = DEF_MIN_PULSE_CYCLES,
  parameter int CYCLES_PER_DEG   = DEF_CYCLES_PER_DEG,
  parameter int MAX_ANGLE        = DEF_MAX_ANGLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [POS_W-1:0]  motorposition1,
  input  logic [POS_W-1:0]  motorposition2,
  input  logic [POS_W-1:0]  motorposition3,
  input  logic [POS_W-1:0]  motorposition4,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_tick,
  output logic              busy,
  output logic [NUM_CH-1:0] clamp_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_PULSE_CYCLES);

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]  shadow_r [NUM_CH];
  logic [CNT_W-1:0]  width_s  [NUM_CH];
  logic [POS_W-1:0]  pos_s    [NUM_CH];
  logic [NUM_CH-1:0] clamp_s;
  logic              frame_end_s;
  logic              load_s;
  logic [NUM_CH-1:0] pwm_nxt_s;
  logic              tick_nxt_s;
  logic              busy_nxt_s;

  assign pos_s[0] = motorposition1;
  assign pos_s[1] = motorposition2;
  assign pos_s[2] = motorposition3;
  assign pos_s[3] = motorposition4;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_calc
    servo_width_calc #(
      .MIN_PULSE_CYCLES(MIN_PULSE_CYCLES),
      .CYCLES_PER_DEG  (CYCLES_PER_DEG),
      .MAX_ANGLE       (MAX_ANGLE)
    ) u_calc (
      .pos  (pos_s[g]),
      .width(width_s[g]),
      .clamp(clamp_s[g])
    );
  end

  // Shadows load when a new frame begins: leaving IDLE, or wrapping while staying active
  assign frame_end_s = (state_r != IDLE) && (cnt_r == LAST_CNT);
  assign load_s      = (state_nxt_s != IDLE) && ((state_r == IDLE) || frame_end_s);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_nxt_s = RUN;
        else        state_nxt_s = IDLE;
      end
      RUN, DRAIN: begin
        if (enable)           state_nxt_s = RUN;
        else if (frame_end_s) state_nxt_s = IDLE;
        else                  state_nxt_s = DRAIN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Frame counter next value: held at zero when idle, wraps at the frame boundary
  always_comb begin
    cnt_nxt_s = {CNT_W{1'b0}};
    if ((state_r == IDLE) || (state_nxt_s == IDLE) || frame_end_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // FSM output logic: next values of the registered pins
  always_comb begin
    pwm_nxt_s  = {NUM_CH{1'b0}};
    tick_nxt_s = 1'b0;
    busy_nxt_s = (state_nxt_s != IDLE);
    if (state_r != IDLE) begin
      tick_nxt_s = (cnt_r == {CNT_W{1'b0}});
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_nxt_s[i] = (cnt_r < shadow_r[i]);
      end
    end else begin
      tick_nxt_s = 1'b0;
      pwm_nxt_s  = {NUM_CH{1'b0}};
    end
  end

  // Frame counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Per-frame width shadows and sticky clamp flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_r[i] <= MIN_W;
      end
      clamp_err <= {NUM_CH{1'b0}};
    end else if (load_s) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_r[i] <= width_s[i];
      end
      clamp_err <= clamp_err | clamp_s;
    end
  end

  // Registered output pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out    <= {NUM_CH{1'b0}};
      frame_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pwm_out    <= pwm_nxt_s;
      frame_tick <= tick_nxt_s;
      busy       <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Scoreboard bench for servo_pwm_driver: a frame-level reference model queues expected pulse
// widths and tick times; a monitor measures the pins and compares.
module tb_servo_pwm_driver;

  localparam int PERIOD = 1000;
  localparam int MINP   = 50;
  localparam int CPD    = 2;
  localparam int MAXA   = 180;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] pos [4];
  logic [3:0] pwm_out;
  logic       frame_tick;
  logic       busy;
  logic [3:0] clamp_err;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         infr     = 1'b0;
  int         fpos     = 0;
  logic [3:0] exp_clamp = 4'b0000;
  int         exp_w_q [4][$];
  int         exp_tick_q [$];

  servo_pwm_driver #(
    .PERIOD_CYCLES   (PERIOD),
    .MIN_PULSE_CYCLES(MINP),
    .CYCLES_PER_DEG  (CPD),
    .MAX_ANGLE       (MAXA)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .motorposition1(pos[0]),
    .motorposition2(pos[1]),
    .motorposition3(pos[2]),
    .motorposition4(pos[3]),
    .pwm_out       (pwm_out),
    .frame_tick    (frame_tick),
    .busy          (busy),
    .clamp_err     (clamp_err)
  );

  always #5 clk = ~clk;

  function automatic int ref_width(int p);
    return MINP + ((p > MAXA) ? MAXA : p) * CPD;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame lasts PERIOD cycles; a new one begins whenever enable is seen
  // high while no frame is running or as the running frame ends.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        infr = 1'b0;
        fpos = 0;
      end else if (infr && fpos != PERIOD - 1) begin
        fpos++;
      end else if (enable) begin
        infr = 1'b1;
        fpos = 0;
        exp_tick_q.push_back(cyc + 1);
        for (int i = 0; i < 4; i++) begin
          exp_w_q[i].push_back(ref_width(int'(pos[i])));
          if (pos[i] > MAXA) exp_clamp[i] = 1'b1;
        end
      end else begin
        infr = 1'b0;
        fpos = 0;
      end
    end
  end

  // Monitor: measures pulse lengths and tick times on the falling clock edge
  initial begin
    int         run [4];
    logic [3:0] prev;
    prev = 4'b0000;
    for (int i = 0; i < 4; i++) run[i] = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev = 4'b0000;
        for (int i = 0; i < 4; i++) run[i] = 0;
        continue;
      end
      check("busy", busy, infr);
      check("clamp_err", clamp_err, exp_clamp);
      if (frame_tick) begin
        if (exp_tick_q.size() == 0) check("unexpected_tick", cyc, -1);
        else                        check("tick_cycle", cyc, exp_tick_q.pop_front());
      end
      for (int ch = 0; ch < 4; ch++) begin
        if (pwm_out[ch]) begin
          if (!prev[ch]) check($sformatf("rise_with_tick_ch%0d", ch + 1), frame_tick, 1);
          run[ch]++;
        end else if (prev[ch]) begin
          if (exp_w_q[ch].size() == 0) check($sformatf("unexpected_pulse_ch%0d", ch + 1), run[ch], -1);
          else check($sformatf("width_ch%0d", ch + 1), run[ch], exp_w_q[ch].pop_front());
          run[ch] = 0;
        end
      end
      prev = pwm_out;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fpos(int n);
    int k;
    k = 0;
    while (!(infr && fpos == n) && k < 3 * PERIOD) begin
      step();
      k++;
    end
    if (!(infr && fpos == n)) check("wait_fpos_timeout", fpos, n);
  endtask

  task automatic frames(int n);
    repeat (n) begin
      wait_fpos(PERIOD - 1);
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_w_q[i].delete();
    exp_tick_q.delete();
    exp_clamp = 4'b0000;
    infr      = 1'b0;
    fpos      = 0;
    step(3);
    check("rst_pwm", pwm_out, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_clamp", clamp_err, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    enable = 1'b0;
    pos[0] = 8'd0; pos[1] = 8'd90; pos[2] = 8'd180; pos[3] = 8'd20;
    do_reset();
    step(2);

    // Basic widths 50/230/410/90
    enable = 1'b1;
    step();
    frames(2);

    // Mid-frame change only takes effect next frame
    pos[0] = 8'd90;
    frames(1);
    wait_fpos(100);
    pos[0] = 8'd20;
    frames(2);

    // Clamp and sticky flag
    pos[0] = 8'd90;
    pos[2] = 8'd200;
    frames(1);
    pos[2] = 8'd45;
    frames(2);
    check("clamp_sticky", clamp_err, 4'b0100);

    // Drain to idle
    wait_fpos(300);
    enable = 1'b0;
    wait_fpos(PERIOD - 1);
    step();
    check("drain_busy_low", busy, 0);
    step(1500);

    // Drain then re-enable mid-frame
    enable = 1'b1;
    step();
    frames(1);
    wait_fpos(300);
    enable = 1'b0;
    wait_fpos(600);
    enable = 1'b1;
    frames(2);
    check("reenable_busy", busy, 1);

    // Deassert on the wrap cycle
    wait_fpos(PERIOD - 1);
    enable = 1'b0;
    step();
    check("wrap_deassert_busy", busy, 0);
    step(1200);

    // Randomized positions and enable toggles
    enable = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 199) == 0) pos[$urandom_range(0, 3)] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1499) == 0) enable = ~enable;
      step();
    end

    // Async reset in the high phase of a 230-cycle pulse
    enable = 1'b1;
    pos[0] = 8'd90;
    step();
    frames(2);
    wait_fpos(120);
    #1;
    check("pwm_high_before_reset", pwm_out[0], 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", pwm_out, 0);
    do_reset();
    frames(2);
    enable = 1'b0;
    step(1200);

    check("tick_queue_empty", exp_tick_q.size(), 0);
    for (int i = 0; i < 4; i++) check($sformatf("width_queue_empty_ch%0d", i + 1), exp_w_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
- Final stage of the roulette-wheel actuator path. Consumes the four 8-bit servo position words produced by the motor sequencing logic and drives four hobby-servo PWM pins.
- Each output carries one pulse per fixed frame. Pulse width is linear in the commanded angle.
- Position words are captured once per frame, so a change from the sequencer never truncates or stretches a pulse that is already in flight.

Parameters:
- PERIOD_CYCLES, 2_000_000, frame length in clk cycles (20 ms at 100 MHz).
- MIN_PULSE_CYCLES, 100_000, pulse width at angle 0 (1 ms).
- CYCLES_PER_DEG, 555, added width per degree.
- MAX_ANGLE, 180, largest legal angle; larger inputs are clamped to it.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- enable  in  1  run request from the processor-side control.
- motorposition1..motorposition4  in  8 each  commanded angle in degrees.
- pwm_out  out  4  servo pins; bit i-1 corresponds to motorposition i.
- frame_tick  out  1  one-cycle pulse at the start of each driven frame.
- busy  out  1  high while in RUN or DRAIN.
- clamp_err  out  4  sticky flag per channel: a position above MAX_ANGLE was latched.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, shadow widths=MIN_PULSE_CYCLES.
  - pwm_out=0, frame_tick=0, busy=0, clamp_err=0.
- Width computation, per channel:
  - a = (pos > MAX_ANGLE) ? MAX_ANGLE : pos.
  - width = MIN_PULSE_CYCLES + a*CYCLES_PER_DEG, computed in 32 bits unsigned.
  - Designer guarantees width < PERIOD_CYCLES.
  - A clamp event sets clamp_err[i] only on the cycle the shadow is loaded. It clears only on reset.
- Frame counter:
  - cnt runs 0..PERIOD_CYCLES-1 while state != IDLE and wraps to 0.
  - cnt is held at 0 in IDLE.
- Shadow load: all four shadow widths load simultaneously on the edge where cnt becomes 0 for a new frame, i.e. IDLE->RUN and each RUN wrap. Inputs are ignored at every other time.
- FSM:
  - IDLE: outputs low. enable=1 -> RUN; the shadow loads on the same edge.
  - RUN: enable=0 mid-frame -> DRAIN, and the current frame completes. At a wrap with enable=1, stay in RUN and start a new frame.
  - DRAIN: on cnt==PERIOD_CYCLES-1 -> IDLE, with no new frame. enable=1 while in DRAIN -> back to RUN with no gap; the next wrap loads the shadow normally.
  - enable=0 on the exact cycle cnt==PERIOD_CYCLES-1 in RUN -> IDLE directly. No extra frame is started.
- Outputs:
  - All outputs are registered.
  - pwm_out[i] <= (state != IDLE) && (cnt < shadow_width[i]). The pin is therefore high for exactly width_i consecutive cycles, starting one cycle after cnt==0.
  - frame_tick <= (state != IDLE) && (cnt == 0). It is coincident with the rising edges of pwm_out.
  - busy <= (next state != IDLE).
- Reset mid-pulse: pwm_out drops immediately (asynchronously). No partial frame resumes after release.

Decomposition:
- Package servo_pkg:
  - POS_W=8, CNT_W=32.
  - Default timing constants.
  - FSM enum {IDLE, RUN, DRAIN}.
- One sub-module, servo_width_calc: combinational clamp plus multiply-add. Outputs width[31:0] and a clamp flag. Instantiated four times.
- Top level holds the counter, FSM, shadows and output registers.

Test Plan (bench overrides: PERIOD_CYCLES=1000, MIN_PULSE_CYCLES=50, CYCLES_PER_DEG=2, MAX_ANGLE=180):
- Basic: reset, positions 0/90/180/20, enable=1 held -> pulse widths 50/230/410/90 cycles, repeating every 1000 cycles; frame_tick once per 1000 cycles, aligned with the pwm rising edges.
- Mid-frame change: in frame 1 with ch1=90, set ch1=20 at cnt=100 -> frame 1 ch1 stays 230 cycles; frame 2 ch1 is 90 cycles.
- Clamp: ch3=200 -> ch3 width 410; clamp_err[2]=1 and stays 1 after the input returns to 45 (width 140). Other clamp_err bits stay 0.
- Drain and re-enable:
  - enable=0 at cnt=300 -> the current frame finishes and busy falls after cnt=999; no further frame_tick.
  - enable=0 at cnt=300, then enable=1 at cnt=600 -> frames continue unbroken.
- Wrap-edge deassert: enable=0 exactly at cnt=999 -> IDLE; no frame_tick follows.
- Async reset: assert rst_n=0 at cnt=120 during the high phase -> pwm_out=0 before the next clk edge. After release with enable=1, a fresh frame starts with a fully correct 230-cycle pulse.
